uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive end of the user-project UART: deserialises the 8N1 stream arriving on the user-area RX pin (mprj_io[5], driven by the bench UART transmitter) into bytes. Received bytes are buffered in a small FIFO and drained through a valid/ready pop port, which the Wishbone register block reads. Also reports framing errors and FIFO overrun.

## Interface
- CLKS_PER_BIT, 347, core clocks per bit (40 MHz / 115200); minimum 8
- FIFO_DEPTH, 4, byte entries; power of two, ≥ 2
- wb_clk_i  in  1  core clock
- wb_rst_i  in  1  asynchronous, active-high reset
- ser_rx  in  1  serial input, idle high, asynchronous to wb_clk_i
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop request; pop occurs when rx_valid & rx_ready at a rising edge
- rx_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky: byte received while FIFO full
- clr_overrun  in  1  clears overrun on the next edge

## Operation
- ser_rx passes through a 2-flop synchroniser (reset to 1); all logic uses the synchronised rx_s.
- FSM states:
  - IDLE: bit counter and baud counter are 0. A falling rx_s (previous 1, now 0) moves to START.
  - START: counts CLKS_PER_BIT/2 (integer division). At terminal count, rx_s=0 moves to DATA with the baud counter reset. rx_s=1 is a false start and returns to IDLE with no flags.
  - DATA: samples rx_s every CLKS_PER_BIT clocks and shifts it LSB-first into an 8-bit shift register. After the 8th sample, moves to STOP.
  - STOP: samples after CLKS_PER_BIT clocks.
    - rx_s=1: push the byte, or set overrun and drop the byte if the FIFO is full.
    - rx_s=0: pulse frame_err and discard the byte.
    - Either way, go to IDLE.
- Returning to IDLE on the mid-stop sample allows back-to-back frames with one stop bit.
- FIFO:
  - Read/write pointers have one extra wrap bit.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - Push and pop in the same cycle with the FIFO full: the pop frees a slot and the push is accepted, so no overrun. Occupancy stays unchanged.
  - Push and pop in the same cycle with the FIFO empty: the push is accepted and the pop is ignored, because rx_valid=0.
  - A pop request with rx_valid=0 has no effect.
- overrun: set has priority over clr_overrun in the same cycle.

## Timing
- Reset values: rx_valid=0, rx_count=0, frame_err=0, overrun=0, FSM=IDLE, pointers=0.
- rx_data is registered from FIFO storage; its value is undefined until the first push.
- Reset asserted mid-frame aborts immediately, with no push and no flags. After release, the FSM re-arms on the next falling edge.
- Pin-to-sample latency is 2 clocks (synchroniser).
- Start edge to data-bit-k sample: 2 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT clocks.
- rx_valid rises 1 clock after the stop-bit sample edge.
- frame_err pulses in the same cycle that the push would have occurred.
- Pop: rx_data and rx_count update on the edge where rx_valid & rx_ready; the next head appears the cycle after.
- Glitch rejection: a low pulse shorter than CLKS_PER_BIT/2 clocks is a false start.

## Structure
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - DATA_BITS=8
  - default CLKS_PER_BIT constant (shared with the transmitter)
- Sub-module uart_sync_fifo (parameter DEPTH, 8-bit): push/pop/full/empty/count, reusable by the TX side.

## Test plan
- Single byte: CLKS_PER_BIT=16, send 0xA5 with one stop bit → rx_valid rises 1 clock after the stop sample; rx_data=0xA5, rx_count=1; pop → rx_valid=0.
- Burst of 5 back-to-back frames 0x01..0x05, FIFO_DEPTH=4, no pops:
  - first four are retained, overrun=1 after the 5th;
  - pops return 0x01..0x04;
  - clr_overrun → overrun=0.
- Framing error: send 0x3C with the stop bit held low → frame_err pulses once, rx_count stays 0. The next valid frame 0x55 is received correctly.
- False start: low pulse of 5 clocks (less than 8) → FSM returns to IDLE, no push, no flags. A following 0x0F frame is received.
- Simultaneous push/pop at full: FIFO full with 0x10..0x13, rx_ready held high as frame 0x14 completes →
  - 0x10 popped;
  - 0x14 accepted, no overrun;
  - rx_count stays 4.
- Reset mid-frame: assert wb_rst_i after bit 3 of 0x99 → all outputs return to reset values asynchronously. After release, frame 0x77 is received as 0x77.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing, receiver FSM states.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 347;   // 40 MHz / 115200

    typedef logic [DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Serial input, pop port and status of the UART receiver.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          ser_rx;
    uart_byte_t    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [CW-1:0] rx_count;
    logic          frame_err;
    logic          overrun;
    logic          clr_overrun;

    // Receiver side
    modport slave (
        input  ser_rx,
        input  rx_ready,
        input  clr_overrun,
        output rx_data,
        output rx_valid,
        output rx_count,
        output frame_err,
        output overrun
    );

    // Consumer side (register block / line driver)
    modport master (
        output ser_rx,
        output rx_ready,
        output clr_overrun,
        input  rx_data,
        input  rx_valid,
        input  rx_count,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with wrap-bit pointers and a registered head; reusable by the TX side.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  uart_byte_t             i_push_data,
    input  logic                   i_pop,
    output uart_byte_t             o_data,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    uart_byte_t    r_mem [DEPTH];
    uart_byte_t    r_data;
    uart_byte_t    w_head;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_rd_next;
    logic [PW-1:0] r_count;
    logic [PW-1:0] w_count_next;
    logic          r_valid;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Accept/reject decisions, next pointers and the head byte after this edge
    always_comb begin
        w_empty      = (r_wr_ptr == r_rd_ptr);
        w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop_ok     = i_pop & ~w_empty;
        // a same-cycle pop frees the slot a push into a full FIFO needs
        w_push_ok    = i_push & (~w_full | w_pop_ok);
        o_overflow_c = i_push & ~w_push_ok;
        w_wr_next    = r_wr_ptr + PW'(w_push_ok);
        w_rd_next    = r_rd_ptr + PW'(w_pop_ok);
        w_count_next = w_wr_next - w_rd_next;
        // bypass when the byte being written becomes the new head
        if (w_push_ok && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0])) begin
            w_head = i_push_data;
        end else begin
            w_head = r_mem[w_rd_next[AW-1:0]];
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            r_data   <= w_head;
        end
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronise, deserialise LSB-first, buffer bytes in a FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
)(
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    uart_rx_fifo_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic              r_sync1;
    logic              r_rx_s;
    logic              r_rx_prev;
    uart_state_e       r_state;
    uart_state_e       w_state_next;
    logic [CNT_W-1:0]  r_baud_cnt;
    logic [CNT_W-1:0]  w_baud_next;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BIT_W-1:0]  w_bit_next;
    uart_byte_t        r_shift;
    uart_byte_t        w_shift_next;
    logic              w_push_c;
    logic              w_frame_err_next;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_overflow_c;
    uart_byte_t        w_fifo_data;
    logic              w_fifo_valid;
    logic [CW-1:0]     w_fifo_count;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= bus.ser_rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    // Receiver FSM state and datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
        end
    end

    // Next state, bit timing and stop-bit verdict
    always_comb begin
        w_state_next     = r_state;
        w_baud_next      = r_baud_cnt;
        w_bit_next       = r_bit_cnt;
        w_shift_next     = r_shift;
        w_push_c         = 1'b0;
        w_frame_err_next = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_baud_next = '0;
                w_bit_next  = '0;
                if (r_rx_prev && !r_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_baud_cnt == HALF_LAST) begin
                    w_baud_next  = '0;
                    // line back high at mid-start means a glitch, not a frame
                    w_state_next = r_rx_s ? IDLE : DATA;
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_baud_next  = '0;
                    w_shift_next = {r_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_next   = '0;
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    // leave at mid-stop so the next start edge is not missed
                    w_baud_next      = '0;
                    w_state_next     = IDLE;
                    w_push_c         = r_rx_s;
                    w_frame_err_next = ~r_rx_s;
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Framing-error pulse and sticky overrun (set wins over clear)
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err_next;
            if (w_overflow_c) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .i_push       (w_push_c),
        .i_push_data  (r_shift),
        .i_pop        (bus.rx_ready),
        .o_data       (w_fifo_data),
        .o_valid      (w_fifo_valid),
        .o_count      (w_fifo_count),
        .o_overflow_c (w_overflow_c)
    );

    assign bus.rx_data   = w_fifo_data;
    assign bus.rx_valid  = w_fifo_valid;
    assign bus.rx_count  = w_fifo_count;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks/bit with a 4-entry FIFO.
module tb_uart_rx_fifo;

    localparam int unsigned C     = 16;
    localparam int unsigned DEPTH = 4;
    // posedges from the start-bit drive to just before the stop-bit sample edge
    localparam int unsigned PRE_STOP = 1 + 2 + C/2 + 9*C - 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   fe_pulses;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus();

    uart_rx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count frame_err pulses, sampled mid-cycle
    always @(negedge clk) if (bus.frame_err === 1'b1) fe_pulses++;

    // drive one frame starting now (called just after a negedge)
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.ser_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.ser_rx = b[i];
            repeat (C) @(negedge clk);
        end
        bus.ser_rx = stop_bit;
        repeat (C) @(negedge clk);
        bus.ser_rx = 1'b1;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ser_rx = 1'b1;
        bus.rx_ready = 1'b0;
        bus.clr_overrun = 1'b0;
        wait_clks(3);
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rx_valid); end
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.rx_count); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        rst = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_single();
        @(negedge clk);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (PRE_STOP) @(posedge clk);
                #1;
                checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%b exp=0", bus.rx_valid); end
                @(posedge clk);
                #1;
                checks++; if (bus.rx_valid !== 1'b1) begin failures++; $display("FAIL single_valid_rise got=%b exp=1", bus.rx_valid); end
                checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus.rx_data); end
                checks++; if (bus.rx_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.rx_count); end
            end
        join
        pop_one();
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", bus.rx_valid); end
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", bus.rx_count); end
        wait_clks(5);
    endtask

    task automatic test_burst();
        @(negedge clk);
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        checks++; if (bus.rx_count !== 3'd4) begin failures++; $display("FAIL burst_count4 got=%0d exp=4", bus.rx_count); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL burst_no_overrun got=%b exp=0", bus.overrun); end
        send_frame(8'h05, 1'b1);
        wait_clks(5);
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL burst_overrun got=%b exp=1", bus.overrun); end
        checks++; if (bus.rx_count !== 3'd4) begin failures++; $display("FAIL burst_count_full got=%0d exp=4", bus.rx_count); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.rx_data !== 8'(i)) begin failures++; $display("FAIL burst_pop_data got=%h exp=%h", bus.rx_data, 8'(i)); end
            pop_one();
        end
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL burst_drained got=%b exp=0", bus.rx_valid); end
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL burst_overrun_sticky got=%b exp=1", bus.overrun); end
        @(negedge clk);
        bus.clr_overrun = 1'b1;
        @(posedge clk);
        #1 bus.clr_overrun = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL burst_clr_overrun got=%b exp=0", bus.overrun); end
        wait_clks(5);
    endtask

    task automatic test_frame_err();
        int fe_before;
        fe_before = fe_pulses;
        @(negedge clk);
        fork
            send_frame(8'h3C, 1'b0);
            begin
                repeat (PRE_STOP) @(posedge clk);
                #1;
                checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL ferr_early got=%b exp=0", bus.frame_err); end
                @(posedge clk);
                #1;
                checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse got=%b exp=1", bus.frame_err); end
                @(posedge clk);
                #1;
                checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL ferr_one_cycle got=%b exp=0", bus.frame_err); end
            end
        join
        wait_clks(20);
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL ferr_count got=%0d exp=0", bus.rx_count); end
        checks++; if (fe_pulses - fe_before !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", fe_pulses - fe_before); end
        @(negedge clk);
        send_frame(8'h55, 1'b1);
        wait_clks(5);
        checks++; if (bus.rx_data !== 8'h55 || bus.rx_count !== 3'd1) begin failures++; $display("FAIL ferr_next_frame got=%h/%0d exp=55/1", bus.rx_data, bus.rx_count); end
        pop_one();
        wait_clks(5);
    endtask

    task automatic test_false_start();
        int fe_before;
        fe_before = fe_pulses;
        @(negedge clk);
        bus.ser_rx = 1'b0;
        repeat (5) @(negedge clk);
        bus.ser_rx = 1'b1;
        wait_clks(3*C);
        checks++; if (bus.rx_valid !== 1'b0 || bus.rx_count !== 3'd0) begin failures++; $display("FAIL glitch_push got=%b/%0d exp=0/0", bus.rx_valid, bus.rx_count); end
        checks++; if (fe_pulses != fe_before || bus.overrun !== 1'b0) begin failures++; $display("FAIL glitch_flags got=%0d/%b exp=0/0", fe_pulses - fe_before, bus.overrun); end
        @(negedge clk);
        send_frame(8'h0F, 1'b1);
        wait_clks(5);
        checks++; if (bus.rx_data !== 8'h0F || bus.rx_count !== 3'd1) begin failures++; $display("FAIL glitch_next_frame got=%h/%0d exp=0f/1", bus.rx_data, bus.rx_count); end
        pop_one();
        wait_clks(5);
    endtask

    task automatic test_full_push_pop();
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        fork
            send_frame(8'h14, 1'b1);
            begin
                repeat (PRE_STOP) @(posedge clk);
                #1;
                checks++; if (bus.rx_count !== 3'd4 || bus.rx_data !== 8'h10) begin failures++; $display("FAIL pp_prefull got=%0d/%h exp=4/10", bus.rx_count, bus.rx_data); end
                bus.rx_ready = 1'b1;
                @(posedge clk);
                #1 bus.rx_ready = 1'b0;
                checks++; if (bus.rx_count !== 3'd4) begin failures++; $display("FAIL pp_count got=%0d exp=4", bus.rx_count); end
                checks++; if (bus.rx_data !== 8'h11) begin failures++; $display("FAIL pp_head got=%h exp=11", bus.rx_data); end
                checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL pp_overrun got=%b exp=0", bus.overrun); end
            end
        join
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.rx_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL pp_drain got=%h exp=%h", bus.rx_data, 8'h10 + 8'(i)); end
            pop_one();
        end
        wait_clks(5);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        send_frame(8'h66, 1'b1);
        wait_clks(5);
        checks++; if (bus.rx_count !== 3'd1) begin failures++; $display("FAIL rmf_preload got=%0d exp=1", bus.rx_count); end
        @(negedge clk);
        fork
            send_frame(8'h99, 1'b1);
            begin
                // bit 3 is sampled 1+2+C/2+4*C posedges after the start drive
                repeat (1 + 2 + C/2 + 4*C + 2) @(posedge clk);
                #1 rst = 1'b1;
                #1;
                checks++; if (bus.rx_valid !== 1'b0 || bus.rx_count !== 3'd0) begin failures++; $display("FAIL rmf_async_fifo got=%b/%0d exp=0/0", bus.rx_valid, bus.rx_count); end
                checks++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin failures++; $display("FAIL rmf_async_flags got=%b/%b exp=0/0", bus.frame_err, bus.overrun); end
            end
        join
        @(negedge clk);
        rst = 1'b0;
        wait_clks(2*C);
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL rmf_no_push got=%b exp=0", bus.rx_valid); end
        @(negedge clk);
        send_frame(8'h77, 1'b1);
        wait_clks(5);
        checks++; if (bus.rx_data !== 8'h77 || bus.rx_count !== 3'd1) begin failures++; $display("FAIL rmf_rearm got=%h/%0d exp=77/1", bus.rx_data, bus.rx_count); end
        pop_one();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        fe_pulses = 0;
        test_reset();
        test_single();
        test_burst();
        test_frame_err();
        test_false_start();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
